// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic family (subtractor today,
// adder/comparator later).
//   state_t    : sequencer states IDLE / RUN / DONE
//   borrow_out : borrow-out of a 1-bit full subtractor computing x - y - bi
// ---------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A borrow is produced when y exceeds x outright, or when x == y and a
    // borrow is already pending from the lower bit.
    function automatic logic borrow_out(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

endpackage

// File: rtl/fs_cell.sv
// ---------------------------------------------------------------------------
// fs_cell
// Combinational 1-bit full subtractor: d = x - y - bi, with borrow-out bo.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow-in
//   d  : difference bit
//   bo : borrow-out
// ---------------------------------------------------------------------------
module fs_cell
    import arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = borrow_out(x, y, bi);

endmodule

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per
// clock, LSB first, through a single full-subtractor cell and a registered
// borrow. Start/busy/done handshake; results are held until the next
// accepted start completes.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only when idle or done
//   a, b  : minuend / subtrahend, captured on accepted start
//   bin   : borrow-in, captured on accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when diff/bout/ovf are updated
//   diff  : difference (mod 2^WIDTH)
//   bout  : borrow-out from the MSB (a < b + bin, unsigned)
//   ovf   : two's-complement overflow
// ---------------------------------------------------------------------------
module serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             bo;
    logic [WIDTH-1:0] res_next;
    logic             last;

    fs_cell u_cell (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    // Result fills from the top so that after WIDTH shifts the first bit
    // computed (the LSB) has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_one
            assign res_next = d;
        end else begin : g_wide
            assign res_next = {d, res[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= bo;
                    res <= res_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff  <= res_next;
                        bout  <= bo;
                        // Operands of opposite sign whose result takes the
                        // subtrahend's sign have left the representable range.
                        ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
// Self-checking bench for serial_sub: an 8-bit instance checked every cycle
// against a transaction-level arithmetic model plus literal expectations,
// and a 1-bit instance checked against the full-subtractor truth table.
// ---------------------------------------------------------------------------
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;
    logic       ovf1;

    int checks = 0;
    int passes = 0;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1),
        .ovf   (ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Transaction-level model of the 8-bit instance: the answer is computed
    // with integer arithmetic at accept time and revealed WIDTH edges later.
    bit         m_valid = 1'b0;
    logic       m_busy, m_done, m_bout, m_ovf;
    logic [7:0] m_diff;
    logic [7:0] p_diff;
    logic       p_bout, p_ovf;
    int         rem;
    int         ures;
    int         sres;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_diff  = 8'h00;
            m_bout  = 1'b0;
            m_ovf   = 1'b0;
            rem     = 0;
        end else if (!m_busy && start) begin
            ures   = int'(a) - int'(b) - int'(bin);
            sres   = int'($signed(a)) - int'($signed(b)) - int'(bin);
            p_diff = ures[7:0];
            p_bout = (ures < 0);
            p_ovf  = (sres > 127) || (sres < -128);
            m_busy = 1'b1;
            m_done = 1'b0;
            rem    = 8;
        end else if (m_busy) begin
            rem = rem - 1;
            if (rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_diff = p_diff;
                m_bout = p_bout;
                m_ovf  = p_ovf;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            check("cycle {busy,done,bout,ovf,diff}",
                  {20'h0, busy, done, bout, ovf, diff},
                  {20'h0, m_busy, m_done, m_bout, m_ovf, m_diff});
    end

    task automatic wait_done(output int nb, output bit seen);
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input string nm);
        int nb;
        bit seen;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, seen);
        check({nm, " done"}, 32'(seen), 32'd1);
        check({nm, " busy cycles"}, nb, 8);
        check({nm, " diff"}, 32'(diff), 32'(ed));
        check({nm, " bout"}, 32'(bout), 32'(eb));
        check({nm, " ovf"}, 32'(ovf), 32'(eo));
    endtask

    // {diff, bout, ovf} for a 1-bit subtract, indexed by {a, b, bin}
    logic [2:0] tbl [8] = '{3'b000, 3'b110, 3'b111, 3'b010,
                            3'b100, 3'b001, 3'b000, 3'b110};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  nb;
        bit  seen;
        bit  saw_done;

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset outputs", {27'h0, busy, done, bout, ovf, 1'b0} | 32'(diff), 32'h0);

        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "5A-3C");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "00-01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF-FF-1");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80-01");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "7F-FF");

        // Start during RUN is ignored; then back-to-back via start held in DONE.
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, seen);
        check("ignored start done", 32'(seen), 32'd1);
        check("ignored start diff", 32'(diff), 32'h0F);
        a = 8'h55; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        check("b2b busy immediately", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(nb, seen);
        check("b2b done", 32'(seen), 32'd1);
        check("b2b diff", 32'(diff), 32'h50);

        // Reset in the middle of RUN aborts with no done pulse.
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort diff", 32'(diff), 32'h00);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no done", 32'(saw_done), 32'd0);
        run_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, "after abort");

        // WIDTH=1 instance against the full-subtractor truth table.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx    = 3'(i);
            a1     = idx[2];
            b1     = idx[1];
            bin1   = idx[0];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("w1 case %0d busy", i), {30'h0, busy1, done1}, 32'b10);
            @(negedge clk);
            check($sformatf("w1 case %0d done", i), {30'h0, busy1, done1}, 32'b01);
            check($sformatf("w1 case %0d {diff,bout,ovf}", i),
                  {29'h0, diff1, bout1, ovf1}, 32'(tbl[i]));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
